// File: rtl/loop_sampler.sv
// loop_sampler: seeds an inverter-ring entropy source, then samples its output through a
// two-flop synchronizer and packs decimated bits into words. Optional stuck-ring detection: LOOP_SAMPLER_STUCK_EN.
module loop_sampler #(
    parameter int SEED_CYCLES = 8,
    parameter int FREE_CYCLES = 16,
    parameter int WORD_WIDTH  = 32,
    parameter int STUCK_LIMIT = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    output logic                  loop_ctrl,
    output logic                  loop_seed,
    input  logic                  loop_d,
    output logic [WORD_WIDTH-1:0] data,
    output logic                  data_valid,
    input  logic                  data_ack,
    output logic                  stuck
);
    localparam int                BIT_W     = $clog2(WORD_WIDTH + 1);
    localparam logic [7:0]        SEED_LAST = 8'(SEED_CYCLES - 1);
    localparam logic [15:0]       FREE_LAST = 16'(FREE_CYCLES - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        RUN  = 2'd2,
        FULL = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic                  sync1_r;
    logic                  d_sync_r;
    logic [7:0]            seed_cnt_r;
    logic [7:0]            seed_cnt_s;
    logic [15:0]           dec_cnt_r;
    logic [15:0]           dec_cnt_s;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic [BIT_W-1:0]      bit_cnt_s;
    logic [WORD_WIDTH-2:0] shift_r;
    logic [WORD_WIDTH-2:0] shift_s;
    logic [WORD_WIDTH-1:0] word_s;
    logic [WORD_WIDTH-1:0] data_s;
    logic                  data_valid_s;
    logic                  loop_ctrl_s;
    logic                  loop_seed_s;

    if (SEED_CYCLES < 1 || SEED_CYCLES > 255 || FREE_CYCLES < 1 || FREE_CYCLES > 65535 ||
        WORD_WIDTH < 2 || WORD_WIDTH > 64 || STUCK_LIMIT < 1) begin : g_bad_params
        $error("loop_sampler: parameter out of legal range");
    end

    // two-flop synchronizer for the asynchronous ring output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r  <= 1'b0;
            d_sync_r <= 1'b0;
        end else begin
            sync1_r  <= loop_d;
            d_sync_r <= sync1_r;
        end
    end

    // next-state, counters and output values; an enable drop overrides everything
    always_comb begin
        state_s      = state_r;
        seed_cnt_s   = seed_cnt_r;
        dec_cnt_s    = dec_cnt_r;
        bit_cnt_s    = bit_cnt_r;
        shift_s      = shift_r;
        data_s       = data;
        data_valid_s = data_valid;
        loop_ctrl_s  = loop_ctrl;
        loop_seed_s  = loop_seed;
        word_s       = {shift_r, d_sync_r};
        if (!enable) begin
            state_s      = IDLE;
            seed_cnt_s   = 8'd0;
            dec_cnt_s    = 16'd0;
            bit_cnt_s    = {BIT_W{1'b0}};
            shift_s      = {(WORD_WIDTH-1){1'b0}};
            data_valid_s = 1'b0;
            loop_ctrl_s  = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s     = SEED;
                    seed_cnt_s  = 8'd0;
                    loop_ctrl_s = 1'b1;
                    loop_seed_s = ~loop_seed;
                end
                SEED: begin
                    if (seed_cnt_r == SEED_LAST) begin
                        state_s     = RUN;
                        loop_ctrl_s = 1'b0;
                        dec_cnt_s   = 16'd0;
                    end else begin
                        seed_cnt_s = seed_cnt_r + 8'd1;
                    end
                end
                RUN: begin
                    if (dec_cnt_r == FREE_LAST) begin
                        dec_cnt_s = 16'd0;
                        if (bit_cnt_r == BIT_LAST) begin
                            // word complete: publish it and clear the accumulator
                            data_s       = word_s;
                            data_valid_s = 1'b1;
                            state_s      = FULL;
                            bit_cnt_s    = {BIT_W{1'b0}};
                            shift_s      = {(WORD_WIDTH-1){1'b0}};
                        end else begin
                            shift_s   = word_s[WORD_WIDTH-2:0];
                            bit_cnt_s = bit_cnt_r + {{(BIT_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        dec_cnt_s = dec_cnt_r + 16'd1;
                    end
                end
                FULL: begin
                    if (data_ack && data_valid) begin
                        state_s      = SEED;
                        seed_cnt_s   = 8'd0;
                        bit_cnt_s    = {BIT_W{1'b0}};
                        shift_s      = {(WORD_WIDTH-1){1'b0}};
                        data_valid_s = 1'b0;
                        loop_ctrl_s  = 1'b1;
                        loop_seed_s  = ~loop_seed;
                    end else begin
                        state_s = FULL;
                    end
                end
                default: begin
                    state_s      = IDLE;
                    seed_cnt_s   = 8'd0;
                    dec_cnt_s    = 16'd0;
                    bit_cnt_s    = {BIT_W{1'b0}};
                    shift_s      = {(WORD_WIDTH-1){1'b0}};
                    data_valid_s = 1'b0;
                    loop_ctrl_s  = 1'b1;
                end
            endcase
        end
    end

    // state, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            seed_cnt_r <= 8'd0;
            dec_cnt_r  <= 16'd0;
            bit_cnt_r  <= {BIT_W{1'b0}};
            shift_r    <= {(WORD_WIDTH-1){1'b0}};
            data       <= {WORD_WIDTH{1'b0}};
            data_valid <= 1'b0;
            loop_ctrl  <= 1'b1;
            loop_seed  <= 1'b0;
        end else begin
            state_r    <= state_s;
            seed_cnt_r <= seed_cnt_s;
            dec_cnt_r  <= dec_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            data       <= data_s;
            data_valid <= data_valid_s;
            loop_ctrl  <= loop_ctrl_s;
            loop_seed  <= loop_seed_s;
        end
    end

`ifdef LOOP_SAMPLER_STUCK_EN
    localparam int               RUN_W   = $clog2(STUCK_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUCK_LIMIT);

    logic             sample_s;
    logic [RUN_W-1:0] run_len_r;
    logic [RUN_W-1:0] run_len_s;
    logic             prev_r;
    logic             prev_s;
    logic             stuck_s;

    assign sample_s = enable && (state_r == RUN) && (dec_cnt_r == FREE_LAST);

    // run length of identical samples; survives reseeding, cleared only by enable drop
    always_comb begin
        run_len_s = run_len_r;
        prev_s    = prev_r;
        stuck_s   = stuck;
        if (!enable) begin
            run_len_s = {RUN_W{1'b0}};
            prev_s    = 1'b0;
            stuck_s   = 1'b0;
        end else if (sample_s) begin
            prev_s = d_sync_r;
            if (run_len_r == {RUN_W{1'b0}} || d_sync_r != prev_r) begin
                run_len_s = {{(RUN_W-1){1'b0}}, 1'b1};
            end else if (run_len_r != RUN_MAX) begin
                run_len_s = run_len_r + {{(RUN_W-1){1'b0}}, 1'b1};
            end else begin
                run_len_s = run_len_r;
            end
            stuck_s = stuck | (run_len_s == RUN_MAX);
        end else begin
            stuck_s = stuck;
        end
    end

    // run-length tracker and sticky flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_len_r <= {RUN_W{1'b0}};
            prev_r    <= 1'b0;
            stuck     <= 1'b0;
        end else begin
            run_len_r <= run_len_s;
            prev_r    <= prev_s;
            stuck     <= stuck_s;
        end
    end
`else
    assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_loop_sampler.sv
// Directed bench for loop_sampler at default parameters: seed timing, bit order,
// handshake, abort, async reset and (build dependent) stuck flag.
module tb_loop_sampler;
`ifdef LOOP_SAMPLER_STUCK_EN
    localparam logic STUCK_EXP = 1'b1;
`else
    localparam logic STUCK_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        loop_ctrl;
    logic        loop_seed;
    logic        loop_d;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ack;
    logic        stuck;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] pat1 = 32'hB5A3_C96E;
    logic [31:0] pat2 = 32'h3C0F_F0A5;
    logic [31:0] pat3 = 32'h8000_0001;
    logic        hold_ok;

    loop_sampler #(
        .SEED_CYCLES(8),
        .FREE_CYCLES(16),
        .WORD_WIDTH (32),
        .STUCK_LIMIT(64)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .loop_ctrl (loop_ctrl),
        .loop_seed (loop_seed),
        .loop_d    (loop_d),
        .data      (data),
        .data_valid(data_valid),
        .data_ack  (data_ack),
        .stuck     (stuck)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called at the negedge after the SEED entry edge; loop_d already holds pat[31].
    task automatic run_word(input logic [31:0] pat, input logic seed, input string tag);
        int hi = 0;
        check_val({tag, " seed"}, 64'(loop_seed), 64'(seed));
        while (loop_ctrl && hi < 20) begin
            hi++;
            @(negedge clk);
        end
        check_val({tag, " ctrl_high"}, 64'(hi), 64'd8);
        for (int k = 1; k <= 32; k++) begin
            repeat (16) @(negedge clk);
            if (k < 32) loop_d = pat[31-k];
            if (k == 31) check_val({tag, " early_valid"}, 64'(data_valid), 64'd0);
        end
        check_val({tag, " valid"}, 64'(data_valid), 64'd1);
        check_val({tag, " data"}, 64'(data), 64'(pat));
    endtask

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        loop_d   = 1'b0;
        data_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst ctrl", 64'(loop_ctrl), 64'd1);
        check_val("rst seed", 64'(loop_seed), 64'd0);
        check_val("rst valid", 64'(data_valid), 64'd0);
        check_val("rst data", 64'(data), 64'd0);
        check_val("rst stuck", 64'(stuck), 64'd0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check_val("idle ctrl", 64'(loop_ctrl), 64'd1);
        check_val("idle seed", 64'(loop_seed), 64'd0);
        check_val("idle valid", 64'(data_valid), 64'd0);

        // first word: seed 1, bit order, 520-cycle latency
        loop_d = pat1[31];
        enable = 1'b1;
        @(negedge clk);
        run_word(pat1, 1'b1, "w1");
        check_val("w1 stuck", 64'(stuck), 64'd0);

        hold_ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (data !== pat1 || data_valid !== 1'b1) hold_ok = 1'b0;
        end
        check_val("hold", 64'(hold_ok), 64'd1);

        loop_d   = pat2[31];
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        check_val("ack valid", 64'(data_valid), 64'd0);
        check_val("ack ctrl", 64'(loop_ctrl), 64'd1);
        run_word(pat2, 1'b0, "w2");
        check_val("w2 stuck", 64'(stuck), 64'd0);

        // abort after 17 bits of a word
        loop_d   = 1'b1;
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        check_val("w3 seed", 64'(loop_seed), 64'd1);
        repeat (8 + 17 * 16) @(negedge clk);
        check_val("w3 mid valid", 64'(data_valid), 64'd0);
        enable = 1'b0;
        @(negedge clk);
        check_val("abort ctrl", 64'(loop_ctrl), 64'd1);
        check_val("abort valid", 64'(data_valid), 64'd0);
        check_val("abort data", 64'(data), 64'(pat2));
        repeat (5) @(negedge clk);

        loop_d = pat3[31];
        enable = 1'b1;
        @(negedge clk);
        run_word(pat3, 1'b0, "w4");

        // enable drop wins over a simultaneous ack
        enable   = 1'b0;
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        check_val("drop+ack valid", 64'(data_valid), 64'd0);
        check_val("drop+ack ctrl", 64'(loop_ctrl), 64'd1);
        repeat (40) @(negedge clk);
        check_val("drop+ack idle ctrl", 64'(loop_ctrl), 64'd1);
        check_val("drop+ack idle seed", 64'(loop_seed), 64'd0);
        check_val("drop+ack data", 64'(data), 64'(pat3));

        // asynchronous reset mid-run
        enable = 1'b1;
        repeat (30) @(negedge clk);
        check_val("pre-rst ctrl", 64'(loop_ctrl), 64'd0);
        #2 reset_n = 1'b0;
        #1;
        check_val("async ctrl", 64'(loop_ctrl), 64'd1);
        check_val("async seed", 64'(loop_seed), 64'd0);
        check_val("async data", 64'(data), 64'd0);
        check_val("async valid", 64'(data_valid), 64'd0);
        enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // constant ring output: stuck after the 64th sample (only when the feature is built)
        loop_d = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        run_word(32'h0000_0000, 1'b1, "s1");
        check_val("s1 stuck", 64'(stuck), 64'd0);
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        run_word(32'h0000_0000, 1'b0, "s2");
        check_val("s2 stuck", 64'(stuck), 64'(STUCK_EXP));
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        repeat (50) @(negedge clk);
        check_val("stuck sticky", 64'(stuck), 64'(STUCK_EXP));
        enable = 1'b0;
        @(negedge clk);
        check_val("stuck clear", 64'(stuck), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/loop_sampler.md
# loop_sampler

Control and capture block for a free-running inverter-ring entropy source. It drives the ring's `ctrl`/`seed` inputs to force a known start state, then releases the ring and samples its asynchronous output `d` through a two-flop synchronizer at a fixed decimation interval. Samples are packed into words and handed to the consumer over a valid/ack handshake. It sits between one ring oscillator instance and the entropy collection logic.

## Interface

Parameters:
- `SEED_CYCLES`, 8: cycles `loop_ctrl` is held high per seeding; legal range 1..255.
- `FREE_CYCLES`, 16: RUN-state cycles between consecutive samples; legal range 1..65535.
- `WORD_WIDTH`, 32: bits per output word; legal range 2..64.
- `STUCK_LIMIT`, 64: consecutive identical samples that flag a stuck ring; used only with `LOOP_SAMPLER_STUCK_EN`.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  run request; low aborts and idles.
- `loop_ctrl`  out  1  ring control; 1 forces the ring to `loop_seed`.
- `loop_seed`  out  1  ring seed value.
- `loop_d`  in  1  ring output; asynchronous to `clk`.
- `data`  out  WORD_WIDTH  sampled word; valid while `data_valid` is high.
- `data_valid`  out  1  word available.
- `data_ack`  in  1  consumer accepts word.
- `stuck`  out  1  sticky stuck-ring flag.

## Operation

- All outputs are registered. Reset values: `loop_ctrl`=1, `loop_seed`=0, `data`=0, `data_valid`=0, `stuck`=0; state IDLE, all counters 0.
- `loop_d` passes through two flops (`d_sync`) before any use. Synchronizer flops reset to 0.
- States:
  - IDLE: `loop_ctrl`=1. Moves to SEED when `enable`=1.
  - SEED: `loop_ctrl`=1. On entry `loop_seed` toggles, so successive seedings alternate 1,0,1,... (the first seeding after reset uses 1). Stays SEED_CYCLES cycles, then goes to RUN.
  - RUN: `loop_ctrl`=0. A decimation counter counts 0..FREE_CYCLES-1. At terminal count the block shifts `d_sync` into the shift register LSB, and earlier bits move toward the MSB, so the first sample ends up in `data[WORD_WIDTH-1]`. It then increments the bit counter. When the sample making WORD_WIDTH bits is taken, the block loads `data`, sets `data_valid`, and moves to FULL.
  - FULL: `loop_ctrl`=0, and the ring keeps running but is not sampled. When `data_ack`=1, `data_valid` clears, and the block goes to SEED, reseeding before every word. The bit counter and shift register clear.
- `enable`=0 in any non-IDLE state sends the block to IDLE on the next edge. It clears `data_valid`, the partial word and the counters. `data` keeps its last value. This takes priority over `data_ack`.
- `data_ack` is ignored unless `data_valid`=1.
- `data` is stable while `data_valid`=1.

## Timing

- `enable` rises before edge N: SEED is active from edge N, with `loop_ctrl`=1 for SEED_CYCLES cycles. `loop_ctrl` falls at edge N+SEED_CYCLES.
- The first sample is taken at the FREE_CYCLES-th RUN edge. Synchronizer latency is 2 cycles, so the sampled bit reflects `loop_d` from 2 cycles earlier.
- `data_valid` rises on the same edge as the final sample: edge N+SEED_CYCLES+WORD_WIDTH·FREE_CYCLES.
- Acknowledgment: `data_ack`=1 at edge M makes `data_valid`=0 and `loop_ctrl`=1 from edge M. The next word becomes valid SEED_CYCLES+WORD_WIDTH·FREE_CYCLES cycles later.
- Throughput is one word per SEED_CYCLES+WORD_WIDTH·FREE_CYCLES+(ack wait) cycles.
- If reset asserts mid-operation, all outputs return to reset values immediately (asynchronous). Operation resumes from IDLE after `reset_n` deasserts.

## Configuration

- `LOOP_SAMPLER_STUCK_EN` defined:
  - A run-length counter tracks consecutive identical samples taken in RUN. It saturates and resets to 1 whenever a sample differs from the previous one.
  - When the count reaches STUCK_LIMIT, `stuck` sets. It is sticky until `enable`=0 or reset.
  - The run length is not reset by reseeding. Word production continues regardless of `stuck`.
- Not defined: `stuck` is tied to 0, no run-length logic is built, and STUCK_LIMIT is ignored.

## Test plan

- **Reset and idle:** hold `reset_n` low, then release with `enable`=0 → `loop_ctrl`=1, `loop_seed`=0, `data_valid`=0, `stuck`=0 indefinitely.
- **Seed timing:** defaults, raise `enable` → `loop_ctrl` high for exactly 8 cycles with `loop_seed`=1, then 0. `data_valid` rises 8+32·16=520 cycles after the SEED entry edge.
- **Bit ordering:** drive `loop_d` from a model so the sampled bits are 1,0,1,1,0… (first sample 1) → `data[31]`=1, `data[30]`=0, pattern matches the full 32-sample sequence.
- **Handshake and reseed:** hold `data_ack`=0 for 100 cycles after valid → `data` is unchanged and `data_valid` stays 1. Pulse `data_ack` → `data_valid`=0 and `loop_ctrl`=1 the next cycle, and `loop_seed` toggles to 0.
- **Abort:** drop `enable` at bit 17 of a word → IDLE next edge. Re-enable → a full 520-cycle word with no stale bits. Dropping `enable` while `data_ack`=1 also lands in IDLE.
- **Stuck detection** (with `LOOP_SAMPLER_STUCK_EN`, STUCK_LIMIT=64): tie `loop_d`=0 → `stuck` sets at the 64th sample and stays set across words. Drop `enable` → `stuck`=0. Without the macro, `stuck` stays 0.
